conv_stream_feeder: RTL and testbench
=====================================

# conv_stream_feeder

Host-side companion to the 2D convolution engine. It holds an NxN image and an MxM kernel written by a host, and streams both row-major to the engine on paired byte lanes under a valid/ready handshake. It then collects the (N-M+1)^2 serial results into a readable result buffer and pulses `done`. It sits between the host register interface and the engine's `a`/`b` input and `out` result path.

## Interface
- `N`, 3, image dimension (N >= 2)
- `M`, 2, kernel dimension (1 <= M <= N)
- `W`, 8, element/result width in bits
- `clk` in 1, clock; all logic on rising edge
- `rst` in 1, reset, synchronous, active-high
- `wr_en` in 1, host write strobe
- `wr_sel` in 1, 0 = image store, 1 = kernel store
- `wr_addr` in clog2(N*N), row-major element index (row*dim + col)
- `wr_data` in W, element value
- `start` in 1, begin a run (sampled only in IDLE)
- `busy` out 1, high in SEND and WAIT_RES
- `s_a` out W, image element lane
- `s_b` out W, kernel element lane (0 outside the MxM kernel footprint)
- `s_valid` out 1, stream element valid
- `s_ready` in 1, engine accepts element
- `r_data` in W, result from engine
- `r_valid` in 1, result strobe
- `rd_addr` in clog2(R), R=(N-M+1)^2, result buffer read index
- `rd_data` out W, result at `rd_addr`, registered, 1-cycle latency
- `done` out 1, one-cycle pulse at run completion
- `err` out 1, sticky protocol error

## Operation
- Storage: image array N*N x W, kernel array M*M x W, result array R x W.
- Host writes are accepted only in IDLE. Writes with `wr_addr` >= dim*dim for the selected store are dropped. Writes while `busy` or in DONE are dropped silently.
- FSM: IDLE -> SEND on `start`; SEND -> WAIT_RES after the last handshake (index N*N-1); WAIT_RES -> DONE on the R-th accepted result; DONE -> IDLE unconditionally.
- SEND: row counter `r` and column counter `c` sweep 0..N-1, with `c` fastest; no divider is used.
  - `s_a` = image[r][c].
  - `s_b` = kernel[r][c] if r<M and c<M, else 0.
  - `s_valid`=1 throughout SEND. Outputs hold stable until `s_valid && s_ready`. The counters advance only on a handshake.
- WAIT_RES: each `r_valid` cycle writes `r_data` into result[k] and increments k, for k = 0..R-1 in row-major output order.
- `r_valid` outside WAIT_RES sets `err`; the data is discarded and the buffer is unchanged.
- `start` outside IDLE is ignored. `start` in IDLE clears `err` and the result counter k. Result buffer contents are kept until overwritten.
- `rd_data` is available in any state, registered from result[`rd_addr`]. An out-of-range `rd_addr` returns 0.

## Timing
- Reset values:
  - FSM = IDLE, r=c=k=0.
  - `busy`=0, `s_valid`=0, `s_a`=`s_b`=0, `done`=0, `err`=0, `rd_data`=0.
  - The result buffer is cleared to 0. Image and kernel stores are not cleared.
- `start` high in IDLE at cycle t: SEND at t+1, with `s_valid`=1 and element 0 on the lanes at t+1.
- With `s_ready` held at 1: one element per cycle, so N*N cycles in SEND. Handshake at cycle t presents the next element at t+1.
- Last handshake at cycle t: `s_valid`=0 and state = WAIT_RES at t+1.
- An `r_valid` sample on the same cycle as the final SEND handshake is an error, since the state is not yet WAIT_RES.
- R-th result accepted at cycle t: `done`=1 at t+1 only, `busy`=0 at t+1, IDLE at t+2.
- A host write and `rd_addr` change in the same cycle are independent. A result write and a read of the same index in the same cycle return the old value.
- `rst` mid-run (any state) returns all outputs to reset values on the next edge. No partial `done` is produced.

## Test plan
- Basic stream: N=3, M=2, image=1..9, kernel=1,2,3,4, `s_ready`=1, `start` -> (`s_a`,`s_b`) sequence (1,1)(2,2)(3,0)(4,3)(5,4)(6,0)(7,0)(8,0)(9,0) on 9 consecutive cycles, then `s_valid`=0.
- Backpressure: same data, `s_ready` toggling 1,0,0,1,... -> each element is presented exactly once per handshake, lanes are stable during stalls, and the stream completes after the 9th accept.
- Result collection: after the stream, drive `r_valid` with 0x11,0x22,0x33,0x44 (gaps allowed) -> `done` pulses 1 cycle after 0x44; `rd_addr`=0..3 returns 0x11..0x44 one cycle later; `err`=0.
- Protocol errors:
  - A 5th `r_valid` after DONE -> `err`=1, result[3] still 0x44.
  - The next `start` -> `err`=0.
- Ignored inputs:
  - `start` pulsed mid-SEND -> no restart, sequence unchanged.
  - `wr_en` to image index 0 with 0xFF during SEND -> image[0] stays 1 on the next run.
- Reset mid-run: assert `rst` after 4 handshakes -> next cycle `s_valid`=0, `busy`=0, `rd_data`=0. A new `start` resends from element 0 with the retained image/kernel.

Source files
------------

// File: rtl/conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_stream_feeder
// Brief    : Holds an NxN image and MxM kernel written by the host, streams
//            them row-major on paired lanes (valid/ready) to the convolution
//            engine, then collects (N-M+1)^2 results into a readable buffer.
// Revision : 1.0  initial release
// ============================================================================
module conv_stream_feeder #(
    parameter int N = 3,
    parameter int M = 2,
    parameter int W = 8,
    localparam int NN = N * N,
    localparam int MM = M * M,
    localparam int R  = (N - M + 1) * (N - M + 1),
    localparam int AW = (NN > 1) ? $clog2(NN) : 1,
    localparam int RW = (R > 1) ? $clog2(R) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    output logic          busy,
    output logic [W-1:0]  s_a,
    output logic [W-1:0]  s_b,
    output logic          s_valid,
    input  logic          s_ready,
    input  logic [W-1:0]  r_data,
    input  logic          r_valid,
    input  logic [RW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          done,
    output logic          err
);
    localparam int DW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (MM > 1) ? $clog2(MM) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    logic [W-1:0] img_mem [NN];
    logic [W-1:0] ker_mem [MM];
    logic [W-1:0] res_mem [R];

    state_t        state_q, state_d;
    logic [DW-1:0] r_q, r_d, c_q, c_d;
    logic [AW-1:0] idx_q, idx_d;     // linear image index, tracks r*N+c
    logic [KW-1:0] kidx_q, kidx_d;   // linear kernel index, counts footprint hits
    logic [RW-1:0] k_q, k_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d, s_valid_q, s_valid_d, done_q, done_d;
    logic [W-1:0]  s_a_q, s_a_d, s_b_q, s_b_d, rd_data_q, rd_data_d;
    logic          res_we;
    logic          in_fp_q, in_fp_d;

    assign busy    = busy_q;
    assign s_valid = s_valid_q;
    assign s_a     = s_a_q;
    assign s_b     = s_b_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rd_data = rd_data_q;

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        idx_d   = idx_q;
        kidx_d  = kidx_q;
        k_d     = k_q;
        err_d   = err_q;
        res_we  = 1'b0;
        in_fp_q = (int'(r_q) < M) && (int'(c_q) < M);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    r_d     = '0;
                    c_d     = '0;
                    idx_d   = '0;
                    kidx_d  = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                end
            end
            S_SEND: begin
                if (s_valid_q && s_ready) begin
                    if (idx_q == AW'(NN - 1)) state_d = S_WAIT;
                    idx_d = idx_q + 1'b1;
                    if (in_fp_q) kidx_d = kidx_q + 1'b1;
                    if (c_q == DW'(N - 1)) begin
                        c_d = '0;
                        r_d = r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_valid) begin
                    res_we = 1'b1;
                    k_d    = k_q + 1'b1;
                    if (k_q == RW'(R - 1)) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A result strobe is only legal while waiting for results
        if (r_valid && (state_q != S_WAIT)) err_d = 1'b1;

        in_fp_d   = (int'(r_d) < M) && (int'(c_d) < M);
        s_valid_d = (state_d == S_SEND);
        busy_d    = (state_d == S_SEND) || (state_d == S_WAIT);
        done_d    = (state_d == S_DONE);
        s_a_d     = s_valid_d ? img_mem[idx_d] : '0;
        s_b_d     = (s_valid_d && in_fp_d) ? ker_mem[kidx_d] : '0;
        rd_data_d = (int'(rd_addr) < R) ? res_mem[rd_addr] : '0;
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            idx_q     <= '0;
            kidx_q    <= '0;
            k_q       <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            s_valid_q <= 1'b0;
            done_q    <= 1'b0;
            s_a_q     <= '0;
            s_b_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            idx_q     <= idx_d;
            kidx_q    <= kidx_d;
            k_q       <= k_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            s_valid_q <= s_valid_d;
            done_q    <= done_d;
            s_a_q     <= s_a_d;
            s_b_q     <= s_b_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Host writes land only while idle and only inside the selected store
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            if (!wr_sel && (int'(wr_addr) < NN)) img_mem[wr_addr] <= wr_data;
            if (wr_sel && (int'(wr_addr) < MM))  ker_mem[wr_addr[KW-1:0]] <= wr_data;
        end
    end

    // Result buffer: cleared by reset, filled in arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < R; i++) res_mem[i] <= '0;
        end else if (res_we) begin
            res_mem[k_q] <= r_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_stream_feeder
// Brief    : Directed self-checking bench for conv_stream_feeder (N=3, M=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_stream_feeder;
    logic       clk = 1'b0;
    logic       rst, wr_en, wr_sel, start, s_ready, r_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, r_data;
    logic [1:0] rd_addr;
    logic       busy, s_valid, done, err;
    logic [7:0] s_a, s_b, rd_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_a [9];
    logic [7:0] exp_b [9];

    conv_stream_feeder #(.N(3), .M(2), .W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .r_data  (r_data),
        .r_valid (r_valid),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Runs one stream. bp: ready pattern 1,0,0 repeating. poke: stray start and
    // image write mid-stream. stop_at: return after that many handshakes (-1 = full).
    // rv_last: raise r_valid on the final handshake cycle.
    task automatic run_stream(input bit bp, input bit poke, input int stop_at, input bit rv_last);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_by_start", err, 1'b0);
        while (idx < 9 && cyc < 100) begin
            check("s_valid", s_valid, 1'b1);
            check("busy", busy, 1'b1);
            check($sformatf("s_a[%0d]", idx), s_a, exp_a[idx]);
            check($sformatf("s_b[%0d]", idx), s_b, exp_b[idx]);
            if (stop_at >= 0 && idx == stop_at) break;
            rdy     = bp ? (cyc % 3 == 0) : 1'b1;
            s_ready = rdy;
            start   = poke && (cyc == 4);
            wr_en   = poke && (cyc == 3);
            wr_sel  = 1'b0; wr_addr = 4'd0; wr_data = 8'hFF;
            r_valid = rv_last && rdy && (idx == 8);
            r_data  = 8'h99;
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        s_ready = 1'b0; start = 1'b0; wr_en = 1'b0; r_valid = 1'b0;
        if (cyc >= 100) check("stream_timeout", 1'b0, 1'b1);
        if (stop_at < 0) begin
            check("s_valid_after_last", s_valid, 1'b0);
            check("busy_wait_res", busy, 1'b1);
        end
    endtask

    // Feeds four results (gaps after the 1st and 3rd) and reads them back
    task automatic collect(input logic [31:0] vals, input logic exp_err);
        for (int i = 0; i < 4; i++) begin
            check("done_early", done, 1'b0);
            r_valid = 1'b1;
            r_data  = vals[8*i +: 8];
            @(negedge clk);
            r_valid = 1'b0;
            if (i % 2 == 0) @(negedge clk);
        end
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", i), rd_data, vals[8*i +: 8]);
        end
        check("err_after_collect", err, exp_err);
    endtask

    initial begin
        exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        exp_b = '{8'd1, 8'd2, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; s_ready = 1'b0; r_data = '0; r_valid = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_s_valid", s_valid, 1'b0);
        check("rst_s_a", s_a, 8'd0);
        check("rst_s_b", s_b, 8'd0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_data", rd_data, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) host_wr(1'b0, 4'(i), 8'(i + 1));
        for (int i = 0; i < 4; i++) host_wr(1'b1, 4'(i), 8'(i + 1));
        host_wr(1'b1, 4'd4, 8'hEE);          // beyond kernel footprint: dropped

        // Basic stream with stray start / write mid-SEND
        run_stream(1'b0, 1'b1, -1, 1'b0);
        collect(32'h44332211, 1'b0);

        // Extra result after completion flags an error, buffer untouched
        r_valid = 1'b1; r_data = 8'h55; rd_addr = 2'd3;
        @(negedge clk);
        r_valid = 1'b0;
        check("err_stray_result", err, 1'b1);
        @(negedge clk);
        check("rd3_kept", rd_data, 8'h44);

        // Backpressure run, image[0] must still be 1; r_valid on last handshake
        run_stream(1'b1, 1'b0, -1, 1'b1);
        check("err_rv_on_last_send", err, 1'b1);
        collect(32'hA4A3A2A1, 1'b1);

        // Reset after four handshakes
        run_stream(1'b0, 1'b0, 4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_addr = 2'd0;
        check("midrst_s_valid", s_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_data", rd_data, 8'd0);
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        check("midrst_buf_cleared", rd_data, 8'd0);

        // Fresh run from element 0 with retained stores
        run_stream(1'b0, 1'b0, -1, 1'b0);
        collect(32'h0D0C0B0A, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
